// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer
//   Takes 32-bit {left,right} stereo words from the reverb output through a
//   one-entry holding register. Serializes them onto a Philips-I2S bus
//   (bclk, lrck, sdata) toward the DAC. Both bus clocks come from clk.
//
// Parameters
//   DATA_WIDTH  frame word width (even); each channel is DATA_WIDTH/2 bits
//   CLK_DIV     clk cycles per bclk half-period (>= 2)
//
// Ports
//   clk             system clock, rising edge
//   reset           synchronous, active-high
//   enable          1 = run the bus, 0 = stop at the next frame boundary
//   sample_data     stereo word {left, right}
//   sample_valid    sample_data valid this cycle
//   sample_ready    holding register empty (accept on valid & ready)
//   clear_underrun  pulse, clears the sticky underrun flag
//   bclk            I2S bit clock
//   lrck            I2S word select, 0 = left, 1 = right
//   sdata           I2S serial data, MSB first, one bclk after lrck edge
//   underrun        sticky: a frame started with no new word available
//
// Build option
//   UNDERRUN_MUTE_EN  when defined, an underrun frame is all zeros (mute);
//                     otherwise the last transmitted word is repeated.

module i2s_tx_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] sample_data,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  input  logic                  clear_underrun,
  output logic                  bclk,
  output logic                  lrck,
  output logic                  sdata,
  output logic                  underrun
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SLOT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DATA_WIDTH - 1);
  localparam logic [SLOT_W-1:0] SLOT_HALF = SLOT_W'(DATA_WIDTH / 2);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [DIV_W-1:0]      div_cnt;
  // slot_cnt names the slot that begins at the next falling bclk event
  logic [SLOT_W-1:0]     slot_cnt;
  logic [DATA_WIDTH-1:0] hold_reg;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] last_word;
  logic [DATA_WIDTH-1:0] load_word;

  logic tick;       // divider terminal count, bclk toggles
  logic fall_evt;   // bclk 1->0 this cycle
  logic frame_evt;  // falling event that begins slot 0
  logic load_evt;   // frame boundary while enabled: start a new frame
  logic stop_evt;   // frame boundary while disabled: back to IDLE
  logic accept;
  logic bypass;
  logic starve;

  assign sample_ready = !hold_full;
  assign accept       = sample_valid && !hold_full;
  // hold empty at the load cycle: a word arriving right now goes straight
  // into the frame instead of through the holding register
  assign bypass       = load_evt && !hold_full && sample_valid;
  assign starve       = load_evt && !hold_full && !sample_valid;

  // ---------------------------------------------------------------------
  // FSM: next state and event decode
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    tick      = 1'b0;
    fall_evt  = 1'b0;
    frame_evt = 1'b0;
    load_evt  = 1'b0;
    stop_evt  = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        tick      = (div_cnt == DIV_LAST);
        fall_evt  = tick && bclk;
        frame_evt = fall_evt && (slot_cnt == '0);
        load_evt  = frame_evt && enable;
        stop_evt  = frame_evt && !enable;
        if (stop_evt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Word that enters the shift register at a frame load
  always_comb begin
    load_word = last_word;
    if (hold_full)         load_word = hold_reg;
    else if (sample_valid) load_word = sample_data;
    else begin
`ifdef UNDERRUN_MUTE_EN
      load_word = '0;
`else
      load_word = last_word;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Holding register and sticky underrun
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_reg  <= '0;
      hold_full <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      // hold_full blocks accept, so a drain and a fill never coincide
      if (load_evt && hold_full) begin
        hold_full <= 1'b0;
      end else if (accept && !bypass) begin
        hold_reg  <= sample_data;
        hold_full <= 1'b1;
      end
      // set wins over a simultaneous clear
      if (starve)              underrun <= 1'b1;
      else if (clear_underrun) underrun <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Bus timing and serializer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt   <= '0;
      slot_cnt  <= '0;
      bclk      <= 1'b0;
      lrck      <= 1'b0;
      sdata     <= 1'b0;
      shift_reg <= '0;
      last_word <= '0;
    end else if (state == IDLE || stop_evt) begin
      div_cnt  <= '0;
      slot_cnt <= '0;
      bclk     <= 1'b0;
      lrck     <= 1'b0;
      sdata    <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      bclk    <= !bclk;
      if (fall_evt) begin
        lrck     <= (slot_cnt >= SLOT_HALF);
        slot_cnt <= (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + SLOT_W'(1);
        if (frame_evt) begin
          // one-bit delay: slot 0 still carries the previous word's LSB
          sdata     <= last_word[0];
          shift_reg <= load_word;
          last_word <= load_word;
        end else begin
          sdata     <= shift_reg[DATA_WIDTH-1];
          shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
        end
      end
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
Downstream stage of the reverb block. It accepts each 32-bit stereo word from the reverb output (bits 31:16 left, 15:0 right) through a one-entry holding register with a valid/ready handshake. It serializes the word onto a Philips-I2S bus (BCLK, LRCK, SDATA) toward the audio DAC. It generates both bus clocks from the system clock and flags underruns when no new word arrives in time for a frame.

Parameters:
DATA_WIDTH, 32, frame word width; must be even; each channel is DATA_WIDTH/2 bits.
CLK_DIV, 4, clk cycles per BCLK half-period; must be at least 2. BCLK period = 2*CLK_DIV clk.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
enable  input  1  level; 1 = run the bus, 0 = stop at the next frame boundary.
sample_data  input  DATA_WIDTH  stereo word {left, right}.
sample_valid  input  1  sample_data is valid this cycle.
sample_ready  output  1  holding register is empty; a word is accepted when valid & ready.
clear_underrun  input  1  one-cycle pulse that clears the sticky underrun flag.
bclk  output  1  I2S bit clock.
lrck  output  1  I2S word select; 0 = left, 1 = right.
sdata  output  1  I2S serial data, MSB first.
underrun  output  1  sticky: a frame started with no new word available.

Behaviour:
- Reset (synchronous, while reset=1): state=IDLE, bclk=0, lrck=0, sdata=0, underrun=0, sample_ready=1. The holding register, shift register and last-word register all clear to 0. Reset overrides every other event, including mid-frame; the bus drops to all zeros immediately.
- Holding register: sample_ready = !hold_full. A word is accepted on any cycle where valid=1 and ready=1, in any state.
- FSM IDLE: bclk, lrck and sdata are held at 0 and div_cnt=0. When enable=1, go to RUN on the next cycle.
- FSM RUN, clock divider: div_cnt counts 0..CLK_DIV-1. At the terminal count, bclk toggles and div_cnt wraps to 0.
  - Rising event: bclk goes 0->1.
  - Falling event: bclk goes 1->0.
- Slots: slot counter k runs 0..DATA_WIDTH-1 and advances on each falling event. The first falling event after entering RUN is slot 0 of frame 1.
- lrck, sdata and the slot counter change only on falling events, in the same clk cycle that bclk falls.
- lrck = 0 for slots 0..DATA_WIDTH/2-1 and 1 for the rest.
- I2S one-bit delay: sdata in slot k carries frame-word bit (DATA_WIDTH-k) for k>=1. Slot 0 carries bit 0 of the previous frame's word; on the first frame after reset this bit is 0.
- Frame load at slot 0:
  - If hold_full: move the holding register into the shift register and clear hold_full.
  - Else, if valid=1 in that same cycle: bypass the word directly into the shift register. This is not an underrun.
  - Else (underrun): reload the last transmitted word and set underrun=1.
  - A word accepted in the load cycle either bypasses (hold empty) or waits in hold (hold full). Data is never lost.
- underrun is sticky until reset or clear_underrun. If set and clear happen in the same cycle, set wins.
- Stop: if enable=0 at the falling event that ends slot DATA_WIDTH-1, return to IDLE with bclk, lrck and sdata at 0, and load nothing. Deasserting enable mid-frame never truncates a frame.
- Sample rate = clk / (2*CLK_DIV*DATA_WIDTH). Output latency from a word held ready to its MSB on sdata is one BCLK after the next slot 0.

Optional Feature:
Macro UNDERRUN_MUTE_EN.
- Defined: on underrun, the shift register loads all zeros (mute); underrun still sets.
- Undefined: on underrun, the shift register reloads the last transmitted word (sample repeat), as above.

Test Plan:
- Reset with CLK_DIV=2 -> bclk, lrck, sdata and underrun are 0 and sample_ready=1. enable=1 -> bclk period is 4 clk with 50% duty, and lrck toggles every 16 BCLKs.
- Write 0xA5A5_3C3C before frame 1 -> slot 0 sdata=0. Slots 1..16 show 0xA5A5 MSB first, with lrck going high at slot 16. Slots 17..31 show 0x3C3C bits 15..1. Next slot 0 shows bit 0 (=0). underrun=0.
- No word supplied for frame 2 -> underrun=1 and frame 2 repeats 0xA5A5_3C3C. With UNDERRUN_MUTE_EN, frame 2 is all zeros. clear_underrun pulse -> underrun=0.
- Words 0x1111_2222 and 0x3333_4444 back-to-back mid-frame -> the first is accepted and sample_ready drops. The second is held off until the next slot 0, then accepted. Both are transmitted in order.
- Hold empty, valid asserted exactly in the slot-0 load cycle with 0xFFFF_0000 -> the word is bypassed into the frame and underrun stays 0.
- enable deasserted at slot 5 -> the frame completes through slot 31, then IDLE with all bus outputs 0. reset asserted at slot 10 of a later frame -> all outputs are 0 on the next clk.
